// File: rtl/board_store.sv
// Tetris playfield store: one TYPE_W-bit block type per cell, two
// combinational read ports (video and game logic), single-cell writes,
// a one-cycle wipe and a sequential line-clear engine that removes full
// lines and lets everything above fall toward increasing h.
module board_store #(
  parameter int ROWS   = 11,
  parameter int COLS   = 22,
  parameter int TYPE_W = 3
) (
  input  logic              clk_25_175,
  input  logic              reset,
  input  logic [4:0]        vid_v,
  input  logic [4:0]        vid_h,
  output logic [TYPE_W-1:0] vid_type,
  input  logic [4:0]        g_v,
  input  logic [4:0]        g_h,
  output logic [TYPE_W-1:0] g_type,
  input  logic              wr_en,
  input  logic [4:0]        wr_v,
  input  logic [4:0]        wr_h,
  input  logic [TYPE_W-1:0] wr_type,
  input  logic              wipe,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        lines_cleared
);

  localparam int VW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [4:0] ROW_LIM = 5'(ROWS);
  localparam logic [4:0] COL_LIM = 5'(COLS);
  localparam logic [4:0] LAST_H  = 5'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } state_t;

  logic [TYPE_W-1:0] cells [COLS][ROWS];

  state_t          state;
  logic [4:0]      scan_h;
  logic [4:0]      shift_h;
  logic [4:0]      count;
  logic            col_full;
  logic            wr_ok;
  logic [HW-1:0]   sh_idx;
  logic [HW-1:0]   sh_prev;
  logic [HW-1:0]   scan_idx;

  assign wr_ok    = (wr_v < ROW_LIM) && (wr_h < COL_LIM);
  assign sh_idx   = shift_h[HW-1:0];
  assign sh_prev  = sh_idx - 1'b1;
  assign scan_idx = scan_h[HW-1:0];

  // Video read port: zero latency, out-of-range coordinates read as empty.
  always_comb begin
    vid_type = '0;
    if ((vid_v < ROW_LIM) && (vid_h < COL_LIM))
      vid_type = cells[vid_h[HW-1:0]][vid_v[VW-1:0]];
  end

  // Game-logic read port: same behaviour as the video port.
  always_comb begin
    g_type = '0;
    if ((g_v < ROW_LIM) && (g_h < COL_LIM))
      g_type = cells[g_h[HW-1:0]][g_v[VW-1:0]];
  end

  // A line is full when none of its cells is empty.
  always_comb begin
    col_full = 1'b1;
    for (int v = 0; v < ROWS; v++)
      if (cells[scan_idx][VW'(v)] == '0) col_full = 1'b0;
  end

  // Cell array and line-clear engine. A full line is removed by copying each
  // line from its lower-h neighbour, then the same h is rescanned because a
  // new line has just moved into it.
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      for (int h = 0; h < COLS; h++)
        for (int v = 0; v < ROWS; v++)
          cells[HW'(h)][VW'(v)] <= '0;
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      scan_h        <= '0;
      shift_h       <= '0;
      count         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wipe) begin
            for (int h = 0; h < COLS; h++)
              for (int v = 0; v < ROWS; v++)
                cells[HW'(h)][VW'(v)] <= '0;
          end else if (wr_en && wr_ok) begin
            cells[wr_h[HW-1:0]][wr_v[VW-1:0]] <= wr_type;
          end
          if (start) begin
            busy   <= 1'b1;
            scan_h <= LAST_H;
            count  <= '0;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (col_full) begin
            shift_h <= scan_h;
            count   <= count + 5'd1;
            state   <= ST_SHIFT;
          end else if (scan_h == 5'd0) begin
            state <= ST_DONE;
          end else begin
            scan_h <= scan_h - 5'd1;
          end
        end
        ST_SHIFT: begin
          if (shift_h != 5'd0) begin
            for (int v = 0; v < ROWS; v++)
              cells[sh_idx][VW'(v)] <= cells[sh_prev][VW'(v)];
            shift_h <= shift_h - 5'd1;
          end else begin
            for (int v = 0; v < ROWS; v++)
              cells[HW'(0)][VW'(v)] <= '0;
            state <= ST_SCAN;
          end
        end
        ST_DONE: begin
          done          <= 1'b1;
          lines_cleared <= count;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_store.sv
// Directed bench for board_store: a vector table for writes/reads/wipe,
// then hand-written sequences for line-clear passes and mid-pass events.
module tb_board_store;

  logic       clk_25_175;
  logic       reset;
  logic [4:0] vid_v, vid_h, g_v, g_h;
  logic [2:0] vid_type, g_type;
  logic       wr_en;
  logic [4:0] wr_v, wr_h;
  logic [2:0] wr_type;
  logic       wipe, start;
  logic       busy, done;
  logic [4:0] lines_cleared;

  int checks = 0;
  int errors = 0;

  board_store dut (
    .clk_25_175    (clk_25_175),
    .reset         (reset),
    .vid_v         (vid_v),
    .vid_h         (vid_h),
    .vid_type      (vid_type),
    .g_v           (g_v),
    .g_h           (g_h),
    .g_type        (g_type),
    .wr_en         (wr_en),
    .wr_v          (wr_v),
    .wr_h          (wr_h),
    .wr_type       (wr_type),
    .wipe          (wipe),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared)
  );

  initial clk_25_175 = 1'b0;
  always #5 clk_25_175 = ~clk_25_175;

  typedef struct {
    logic       we;
    logic       wp;
    logic [4:0] wv;
    logic [4:0] wh;
    logic [2:0] wt;
    logic [4:0] rv;
    logic [4:0] rh;
    logic [2:0] ex;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(int we, int wp, int wv, int wh, int wt,
                              int rv, int rh, int ex);
    vec_t r;
    r.we = 1'(we); r.wp = 1'(wp);
    r.wv = 5'(wv); r.wh = 5'(wh); r.wt = 3'(wt);
    r.rv = 5'(rv); r.rh = 5'(rh); r.ex = 3'(ex);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_25_175);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic rd(string name, int v, int h, int exp);
    vid_v = 5'(v); vid_h = 5'(h);
    g_v   = 5'(v); g_h   = 5'(h);
    #1;
    chk({name, "_vid"}, 32'(vid_type), 32'(exp));
    chk({name, "_g"},   32'(g_type),   32'(exp));
  endtask

  task automatic wr(int v, int h, int t);
    wr_en = 1'b1; wr_v = 5'(v); wr_h = 5'(h); wr_type = 3'(t);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wipe_board();
    wipe = 1'b1;
    tick();
    wipe = 1'b0;
  endtask

  task automatic fill_col(int h, int t);
    for (int v = 0; v < 11; v++) wr(v, h, t);
  endtask

  task automatic col_zero(string name, int h);
    for (int v = 0; v < 11; v++) rd(name, v, h, 0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int cyc;
  int busy_cnt;

  initial begin
    reset = 1'b0; wr_en = 1'b0; wipe = 1'b0; start = 1'b0;
    wr_v = '0; wr_h = '0; wr_type = '0;
    vid_v = '0; vid_h = '0; g_v = '0; g_h = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    reset = 1'b1;
    for (int h = 0; h < 22; h++) col_zero("rst_cell", h);
    rd("rst_oor_v", 11, 0, 0);
    rd("rst_oor_h", 0, 22, 0);

    // Table of single-cycle write / wipe operations with a read-back
    vecs[0]  = mk(1, 0,  3,  5, 5,  3,  5, 5);
    vecs[1]  = mk(1, 0, 10, 21, 7, 10, 21, 7);
    vecs[2]  = mk(1, 0, 12,  4, 2, 12,  4, 0);
    vecs[3]  = mk(0, 0,  0,  0, 0,  3,  5, 5);
    vecs[4]  = mk(1, 0,  4, 22, 6,  4, 22, 0);
    vecs[5]  = mk(0, 0,  0,  0, 0, 10, 21, 7);
    vecs[6]  = mk(1, 0,  0,  0, 6,  0,  0, 6);
    vecs[7]  = mk(1, 0, 10,  0, 1, 10,  0, 1);
    vecs[8]  = mk(1, 0,  0, 21, 2, 11, 21, 0);
    vecs[9]  = mk(0, 0,  0,  0, 0,  0, 21, 2);
    vecs[10] = mk(1, 1,  2,  2, 3,  2,  2, 0);
    vecs[11] = mk(0, 0,  0,  0, 0, 10, 21, 0);
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].we; wipe = vecs[i].wp;
      wr_v = vecs[i].wv; wr_h = vecs[i].wh; wr_type = vecs[i].wt;
      tick();
      wr_en = 1'b0; wipe = 1'b0;
      rd($sformatf("vec%0d", i), int'(vecs[i].rv), int'(vecs[i].rh), int'(vecs[i].ex));
    end
    chk("vec_busy", 32'(busy), 32'd0);

    // A: one full line at h=21; its last cell is written in the start cycle
    wipe_board();
    for (int v = 0; v < 10; v++) wr(v, 21, 1);
    wr(0, 20, 4);
    wr_en = 1'b1; wr_v = 5'd10; wr_h = 5'd21; wr_type = 3'd1; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("A_busy_start", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("A_done_cycle", 32'(cyc), 32'd46);
    chk("A_lines", 32'(lines_cleared), 32'd1);
    chk("A_busy_end", 32'(busy), 32'd0);
    tick();
    chk("A_done_pulse", 32'(done), 32'd0);
    rd("A_cell_0_21", 0, 21, 4);
    for (int v = 1; v < 11; v++) rd("A_col21", v, 21, 0);
    col_zero("A_col20", 20);
    col_zero("A_col0", 0);

    // B: full lines at 21 and 19 with a lone block between them
    wipe_board();
    fill_col(21, 1);
    fill_col(19, 2);
    wr(5, 20, 3);
    pulse_start();
    wait_done(cyc);
    chk("B_done_cycle", 32'(cyc), 32'd68);
    chk("B_lines", 32'(lines_cleared), 32'd2);
    rd("B_cell_5_21", 5, 21, 3);
    for (int v = 0; v < 11; v++) if (v != 5) rd("B_col21", v, 21, 0);
    for (int h = 0; h < 21; h++) col_zero("B_low", h);

    // C: empty board
    wipe_board();
    pulse_start();
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
      if (busy === 1'b1) busy_cnt++;
    end
    chk("C_done_cycle", 32'(cyc), 32'd23);
    chk("C_busy_cycles", 32'(busy_cnt), 32'd23);
    chk("C_lines", 32'(lines_cleared), 32'd0);

    // F: start together with wipe clears the board first
    fill_col(21, 6);
    wipe = 1'b1; start = 1'b1;
    tick();
    wipe = 1'b0; start = 1'b0;
    wait_done(cyc);
    chk("F_done_cycle", 32'(cyc), 32'd23);
    chk("F_lines", 32'(lines_cleared), 32'd0);
    col_zero("F_col21", 21);

    // D: write, wipe and start during a pass are all ignored
    wipe_board();
    fill_col(21, 1);
    wr(0, 20, 4);
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    wr_en = 1'b1; wr_v = 5'd3; wr_h = 5'd3; wr_type = 3'd5;
    wipe = 1'b1; start = 1'b1;
    tick();
    wr_en = 1'b0; wipe = 1'b0; start = 1'b0;
    wait_done(cyc);
    chk("D_done_cycle", 32'(cyc + 5), 32'd46);
    chk("D_lines", 32'(lines_cleared), 32'd1);
    rd("D_cell_0_21", 0, 21, 4);
    rd("D_cell_3_3", 3, 3, 0);
    for (int v = 1; v < 11; v++) rd("D_col21", v, 21, 0);
    col_zero("D_col20", 20);
    tick();
    chk("D_idle_after", 32'(busy), 32'd0);

    // E: reset during SHIFT aborts the pass and clears everything
    fill_col(21, 2);
    wr(7, 15, 3);
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
    chk("E_busy_mid", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("E_busy", 32'(busy), 32'd0);
    chk("E_done", 32'(done), 32'd0);
    chk("E_lines", 32'(lines_cleared), 32'd0);
    reset = 1'b1;
    for (int h = 0; h < 22; h++) col_zero("E_cell", h);
    tick(); tick();
    chk("E_stays_idle", 32'(busy), 32'd0);
    chk("E_no_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Playfield memory for the tetris board. Holds one 3-bit block type per cell; type 0 means empty.
- Provides a zero-latency combinational read port for the video stage, addressed by memselector_v/memselector_h, which returns blocktype_mem. A second combinational read port serves game logic.
- Accepts single-cell writes from game logic.
- Runs a sequential line-clear engine: scans the board, removes full lines, compacts the remaining cells and reports how many lines were cleared.

Parameters:
- ROWS, 11, number of v-indices (cells per line).
- COLS, 22, number of h-indices (number of lines); must be ≤ 31.
- TYPE_W, 3, bits per cell.

Ports:
- clk_25_175  input  1  pixel/system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low.
- vid_v  input  5  video read row index (from memselector_v).
- vid_h  input  5  video read column index (from memselector_h).
- vid_type  output  TYPE_W  cell at (vid_v, vid_h); drives blocktype_mem.
- g_v  input  5  game-logic read row index.
- g_h  input  5  game-logic read column index.
- g_type  output  TYPE_W  cell at (g_v, g_h).
- wr_en  input  1  cell write strobe.
- wr_v  input  5  write row index.
- wr_h  input  5  write column index.
- wr_type  input  TYPE_W  value to write.
- wipe  input  1  zero the entire board.
- start  input  1  begin line-clear pass.
- busy  output  1  line-clear engine active.
- done  output  1  one-cycle pulse at the end of a pass.
- lines_cleared  output  5  count from the last completed pass.

Behaviour:
- Reset (reset==0 at a clock edge): all cells := 0; state := IDLE; busy=0, done=0, lines_cleared=0. Reset applied mid-pass aborts the pass immediately with the same values.
- Read ports:
  - Purely combinational from the cell array, zero latency.
  - Index out of range (v ≥ ROWS or h ≥ COLS) returns 0.
  - During a pass, reads reflect the intermediate array contents; no freezing.
- Line definition: line h is the set of cells (0..ROWS-1, h). It is full when every cell ≠ 0. Gravity runs toward increasing h.
- IDLE:
  - wr_en writes wr_type to (wr_v, wr_h) at the edge; out-of-range writes are ignored.
  - wipe zeros every cell in one cycle. If wipe and wr_en are both asserted, wipe wins.
  - start: busy:=1, scan_h:=COLS-1, count:=0, state:=SCAN.
  - start in the same cycle as wr_en: the write lands, and the first scan sees it.
  - start together with wipe: wipe lands, and the pass finds nothing.
- Engine-active ignores: while busy=1, wr_en, wipe and start are ignored.
- SCAN (one column per cycle), evaluating column scan_h:
  - Full: shift_h:=scan_h, count:=count+1, state:=SHIFT.
  - Not full and scan_h==0: state:=DONE.
  - Otherwise: scan_h:=scan_h-1.
- SHIFT (one column per cycle):
  - shift_h > 0: column shift_h := column shift_h-1, then shift_h:=shift_h-1.
  - shift_h == 0: column 0 := all zero, state:=SCAN, with scan_h unchanged so the column that moved in is rescanned.
- DONE (one cycle): done=1, lines_cleared:=count, busy:=0, state:=IDLE.
- lines_cleared holds until the next DONE.
- Timing, counted from the start edge:
  - Board with no full lines: done is high in the cycle COLS+1 edges after start.
  - Each full line found at position h adds h+2 cycles: h+1 for SHIFT and 1 for the rescan.
- Arithmetic: count is 5 bits and cannot overflow because COLS ≤ 31. Index compares are unsigned.

Test Plan:
- Reset, then read every (v,h) on both ports, plus (11,0) and (0,22) → all return 0; busy=0, done=0, lines_cleared=0.
- Write (3,5)=5, (10,21)=7, then (12,4)=2 → vid_type at (3,5)=5 and g_type at (10,21)=7 in the next cycle; out-of-range write changes nothing.
- Fill column 21 with type 1 and set (0,20)=4, then start:
  - done pulses 46 cycles after start (23+22+1); lines_cleared=1.
  - (0,21)=4, column 20 all 0, column 0 all 0.
- Fill columns 21 and 19 fully and set (5,20)=3, then start:
  - lines_cleared=2.
  - (5,21)=3; columns 0..20 all 0.
- Empty board, start → busy high for 23 cycles; done pulses at cycle 23; lines_cleared=0.
- Mid-pass abuse:
  - Assert wr_en, wipe and start mid-pass → all ignored; board result matches the undisturbed run.
  - Pull reset low mid-SHIFT → next cycle busy=0, board all 0.
